// File: rtl/res_mem_arbiter_pkg.sv
// Shared definitions for the result-RAM arbiter.
// Holds default widths, the FSM state encoding and the requester ids.
package res_mem_arbiter_pkg;

  localparam int unsigned AW_DEF       = 14;
  localparam int unsigned DW_DEF       = 8;
  localparam int unsigned LOCK_MAX_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  // Requester ids: distance-transform engine and host port
  localparam logic M_DT   = 1'b0;
  localparam logic M_HOST = 1'b1;

endpackage

// File: rtl/res_mem_arbiter.sv
// Two-requester arbiter for the single-port result RAM.
// Per-cycle round-robin, burst lock with starvation timeout, registered RAM port.
module res_mem_arbiter
  import res_mem_arbiter_pkg::*;
#(
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_wr,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_wr,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          res_rd,
  output logic          res_wr,
  output logic [AW-1:0] res_addr,
  output logic [DW-1:0] res_do,
  input  logic [DW-1:0] res_di
);

  localparam int unsigned CW = $clog2(LOCK_MAX + 1);

  state_t          state;
  state_t          state_nxt;
  logic            last;
  logic            last_nxt;
  logic [CW-1:0]   lock_cnt;
  logic [CW-1:0]   lock_cnt_nxt;
  logic            gnt0;
  logic            gnt1;
  logic            acc;
  logic            acc_id;
  logic            acc_wr;
  logic            acc_lock;
  logic [AW-1:0]   acc_addr;
  logic [DW-1:0]   acc_wdata;
  logic            tag;
  logic            lock_exp;

  // Arbitration, accept mux and FSM next-state
  always_comb begin
    state_nxt    = state;
    last_nxt     = last;
    lock_cnt_nxt = lock_cnt;
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    lock_exp     = (lock_cnt == CW'(LOCK_MAX));

    unique case (state)
      ST_IDLE: begin
        if (m0_req && m1_req) begin
          // last == 1 means m1 was served most recently, so m0 wins the tie
          gnt0 = last;
          gnt1 = ~last;
        end else begin
          gnt0 = m0_req;
          gnt1 = m1_req;
        end
      end
      ST_OWN0: begin
        if (m1_req && lock_exp) gnt1 = 1'b1;
        else                    gnt0 = m0_req;
      end
      ST_OWN1: begin
        if (m0_req && lock_exp) gnt0 = 1'b1;
        else                    gnt1 = m1_req;
      end
      default: ;
    endcase

    if (!reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end

    acc       = gnt0 | gnt1;
    acc_id    = gnt1;
    acc_wr    = gnt1 ? m1_wr    : m0_wr;
    acc_lock  = gnt1 ? m1_lock  : m0_lock;
    acc_addr  = gnt1 ? m1_addr  : m0_addr;
    acc_wdata = gnt1 ? m1_wdata : m0_wdata;

    if (acc) last_nxt = acc_id;

    unique case (state)
      ST_IDLE: begin
        if (acc && acc_lock) begin
          state_nxt    = acc_id ? ST_OWN1 : ST_OWN0;
          lock_cnt_nxt = '0;
        end
      end
      ST_OWN0: begin
        if (gnt1) begin
          lock_cnt_nxt = '0;
        end else if (gnt0 && !m0_lock) begin
          state_nxt    = ST_IDLE;
          lock_cnt_nxt = '0;
        end else if (m1_req && !lock_exp) begin
          lock_cnt_nxt = lock_cnt + CW'(1);
        end
      end
      ST_OWN1: begin
        if (gnt0) begin
          lock_cnt_nxt = '0;
        end else if (gnt1 && !m1_lock) begin
          state_nxt    = ST_IDLE;
          lock_cnt_nxt = '0;
        end else if (m0_req && !lock_exp) begin
          lock_cnt_nxt = lock_cnt + CW'(1);
        end
      end
      default: begin
        state_nxt    = ST_IDLE;
        lock_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      last     <= 1'b1;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  // Registered RAM port and one-bit read-return tag pipeline
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_rd    <= 1'b0;
      res_wr    <= 1'b0;
      res_addr  <= '0;
      res_do    <= '0;
      tag       <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
    end else begin
      res_rd    <= acc & ~acc_wr;
      res_wr    <= acc & acc_wr;
      if (acc) begin
        res_addr <= acc_addr;
        res_do   <= acc_wdata;
        tag      <= acc_id;
      end
      m0_rvalid <= res_rd & (tag == M_DT);
      m1_rvalid <= res_rd & (tag == M_HOST);
    end
  end

  assign m0_gnt   = gnt0;
  assign m1_gnt   = gnt1;
  assign m0_rdata = res_di;
  assign m1_rdata = res_di;

endmodule

// File: tb/tb_res_mem_arbiter.sv
// Self-checking bench for res_mem_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model of the arbitration rules and RAM contents.
module tb_res_mem_arbiter;

  localparam int LOCK_MAX = 16;
  localparam int DEPTH    = 16384;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_wr, m0_lock;
  logic [13:0] m0_addr;
  logic [7:0]  m0_wdata;
  logic        m0_gnt, m0_rvalid;
  logic [7:0]  m0_rdata;
  logic        m1_req, m1_wr, m1_lock;
  logic [13:0] m1_addr;
  logic [7:0]  m1_wdata;
  logic        m1_gnt, m1_rvalid;
  logic [7:0]  m1_rdata;
  logic        res_rd, res_wr;
  logic [13:0] res_addr;
  logic [7:0]  res_do;
  logic [7:0]  res_di;

  int checks = 0;
  int failures = 0;

  res_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .res_rd(res_rd), .res_wr(res_wr), .res_addr(res_addr), .res_do(res_do), .res_di(res_di)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous-read RAM
  logic [7:0] ram [DEPTH];
  always @(posedge clk) begin
    if (res_rd) res_di <= ram[res_addr];
    if (res_wr) ram[res_addr] <= res_do;
  end

  // Reference model state
  logic [7:0]  shadow [DEPTH];
  int          owner, last, wcnt, last_g;
  logic        e_rd, e_wr;
  logic [13:0] e_addr;
  logic [7:0]  e_do;
  logic        p1_v, p2_v;
  int          p1_id, p2_id;
  logic [7:0]  p1_data, p2_data;
  logic        obs_g0, obs_g1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner = -1; last = 1; wcnt = 0; last_g = -1;
    e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_do = '0;
    p1_v = 1'b0; p2_v = 1'b0; p1_id = 0; p2_id = 0; p1_data = '0; p2_data = '0;
  endtask

  function automatic int model_grant();
    logic [1:0] r;
    r = {m1_req, m0_req};
    if (owner < 0) begin
      if (r[0] && r[1]) return 1 - last;
      if (r[0]) return 0;
      if (r[1]) return 1;
      return -1;
    end
    if (r[1-owner] && wcnt == LOCK_MAX) return 1 - owner;
    if (r[owner]) return owner;
    return -1;
  endfunction

  task automatic model_update(input int g);
    logic        rq [2];
    logic        wr [2];
    logic        lk [2];
    logic [13:0] ad [2];
    logic [7:0]  wd [2];
    rq[0] = m0_req; wr[0] = m0_wr; lk[0] = m0_lock; ad[0] = m0_addr; wd[0] = m0_wdata;
    rq[1] = m1_req; wr[1] = m1_wr; lk[1] = m1_lock; ad[1] = m1_addr; wd[1] = m1_wdata;
    p2_v = p1_v; p2_id = p1_id; p2_data = p1_data;
    p1_v = 1'b0;
    e_rd = 1'b0; e_wr = 1'b0;
    if (g >= 0) begin
      e_rd = !wr[g]; e_wr = wr[g]; e_addr = ad[g]; e_do = wd[g];
      if (wr[g]) shadow[ad[g]] = wd[g];
      else begin p1_v = 1'b1; p1_id = g; p1_data = shadow[ad[g]]; end
      last = g;
    end
    if (owner < 0) begin
      if (g >= 0 && lk[g]) begin owner = g; wcnt = 0; end
    end else if (g == 1 - owner) begin
      wcnt = 0;
    end else if (g == owner && !lk[g]) begin
      owner = -1; wcnt = 0;
    end else if (rq[1-owner] && wcnt < LOCK_MAX) begin
      wcnt = wcnt + 1;
    end
  endtask

  // One clock cycle: called at a falling edge with inputs already driven
  task automatic tick();
    int g;
    #1;
    g = model_grant();
    obs_g0 = m0_gnt;
    obs_g1 = m1_gnt;
    chk("gnt0", 32'(m0_gnt), 32'(g == 0));
    chk("gnt1", 32'(m1_gnt), 32'(g == 1));
    chk("res_rd", 32'(res_rd), 32'(e_rd));
    chk("res_wr", 32'(res_wr), 32'(e_wr));
    chk("res_addr", 32'(res_addr), 32'(e_addr));
    chk("res_do", 32'(res_do), 32'(e_do));
    chk("rvalid0", 32'(m0_rvalid), 32'(p2_v && p2_id == 0));
    chk("rvalid1", 32'(m1_rvalid), 32'(p2_v && p2_id == 1));
    if (p2_v) chk("rdata", 32'(p2_id == 1 ? m1_rdata : m0_rdata), 32'(p2_data));
    model_update(g);
    last_g = g;
    @(negedge clk);
  endtask

  task automatic set_m0(input logic req, input logic wr, input logic lock,
                        input logic [13:0] addr, input logic [7:0] wdata);
    m0_req = req; m0_wr = wr; m0_lock = lock; m0_addr = addr; m0_wdata = wdata;
  endtask

  task automatic set_m1(input logic req, input logic wr, input logic lock,
                        input logic [13:0] addr, input logic [7:0] wdata);
    m1_req = req; m1_wr = wr; m1_lock = lock; m1_addr = addr; m1_wdata = wdata;
  endtask

  task automatic gen(input int k);
    logic        rq, wr, lk;
    logic [13:0] ad;
    logic [7:0]  wd;
    rq = ($urandom_range(0, 99) < 70);
    wr = 1'($urandom_range(0, 1));
    lk = ($urandom_range(0, 3) == 0);
    ad = 14'h0200 + 14'($urandom_range(0, 15));
    wd = 8'($urandom);
    if (k == 0) set_m0(rq, wr, lk, ad, wd);
    else        set_m1(rq, wr, lk, ad, wd);
  endtask

  // Keep pending requests up until served, then release them (bounded)
  task automatic drain();
    for (int i = 0; i < 40 && (m0_req || m1_req); i++) begin
      tick();
      if (last_g == 0) m0_req = 1'b0;
      if (last_g == 1) m1_req = 1'b0;
    end
    chk("drain_done", 32'(m0_req | m1_req), 32'(0));
    for (int i = 0; i < 3; i++) tick();
  endtask

  initial begin
    int  g1_cnt, g1_first, g1_second, prev_id;
    logic held0, held1;

    for (int i = 0; i < DEPTH; i++) begin
      ram[i]    = 8'(i) ^ 8'h5A;
      shadow[i] = 8'(i) ^ 8'h5A;
    end
    reset = 1'b0;
    set_m0(1'b1, 1'b0, 1'b0, 14'h0001, 8'h00);
    set_m1(1'b1, 1'b0, 1'b0, 14'h0002, 8'h00);
    @(negedge clk);
    #1;
    chk("rst_gnt0", 32'(m0_gnt), 32'(0));
    chk("rst_gnt1", 32'(m1_gnt), 32'(0));
    chk("rst_rd_wr", 32'({res_rd, res_wr}), 32'(0));
    chk("rst_addr", 32'(res_addr), 32'(0));
    chk("rst_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'(0));
    set_m0(1'b0, 1'b0, 1'b0, 14'h0, 8'h0);
    set_m1(1'b0, 1'b0, 1'b0, 14'h0, 8'h0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();

    // 1: lone m0 read
    set_m0(1'b1, 1'b0, 1'b0, 14'h0081, 8'h00);
    tick();
    chk("t1_gnt", 32'(obs_g0), 32'(1));
    m0_req = 1'b0;
    chk("t1_res_rd", 32'(res_rd), 32'(1));
    chk("t1_res_addr", 32'(res_addr), 32'h0081);
    tick();
    chk("t1_rvalid0", 32'(m0_rvalid), 32'(1));
    chk("t1_rdata", 32'(m0_rdata), 32'h81 ^ 32'h5A);
    chk("t1_rvalid1", 32'(m1_rvalid), 32'(0));
    tick(); tick();

    // 2: both request every cycle, no lock
    set_m0(1'b1, 1'b0, 1'b0, 14'h0010, 8'h00);
    set_m1(1'b1, 1'b0, 1'b0, 14'h0020, 8'h00);
    prev_id = -1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t2_one_gnt", 32'(obs_g0 ^ obs_g1), 32'(1));
      if (prev_id >= 0) chk("t2_alternate", 32'(obs_g1), 32'(prev_id == 0));
      prev_id = obs_g1 ? 1 : 0;
    end
    drain();

    // 3: m0 write then m1 read of the same address
    set_m0(1'b1, 1'b1, 1'b0, 14'h0100, 8'h05);
    tick();
    m0_req = 1'b0;
    set_m1(1'b1, 1'b0, 1'b0, 14'h0100, 8'h00);
    tick();
    m1_req = 1'b0;
    tick();
    chk("t3_rvalid1", 32'(m1_rvalid), 32'(1));
    chk("t3_rdata", 32'(m1_rdata), 32'h05);
    tick(); tick();

    // 4: m0 holds a lock for 40 cycles while m1 waits
    set_m0(1'b1, 1'b0, 1'b1, 14'h0081, 8'h00);
    set_m1(1'b1, 1'b0, 1'b0, 14'h0300, 8'h00);
    g1_cnt = 0; g1_first = -1; g1_second = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (obs_g1) begin
        g1_cnt++;
        if (g1_first < 0) g1_first = i;
        else if (g1_second < 0) g1_second = i;
      end
    end
    chk("t4_m1_count", 32'(g1_cnt), 32'(2));
    chk("t4_first", 32'(g1_first), 32'(LOCK_MAX + 1));
    chk("t4_gap", 32'(g1_second - g1_first), 32'(LOCK_MAX + 1));
    m0_lock = 1'b0;
    drain();

    // 5: locked burst of four m0 reads, last one unlocks
    set_m0(1'b1, 1'b0, 1'b1, 14'h0400, 8'h00);
    tick();
    chk("t5_first", 32'(obs_g0), 32'(1));
    set_m1(1'b1, 1'b0, 1'b0, 14'h0301, 8'h00);
    for (int i = 1; i < 4; i++) begin
      m0_addr = 14'h0400 + 14'(i);
      m0_lock = (i != 3);
      tick();
      chk("t5_own", 32'({obs_g0, obs_g1}), 32'b10);
    end
    m0_req = 1'b0;
    tick();
    chk("t5_m1_next", 32'(obs_g1), 32'(1));
    m1_req = 1'b0;
    drain();

    // 6: reset with two reads in flight
    set_m0(1'b1, 1'b0, 1'b0, 14'h0081, 8'h00);
    tick();
    m0_req = 1'b0;
    set_m1(1'b1, 1'b0, 1'b0, 14'h0082, 8'h00);
    tick();
    chk("t6_inflight", 32'({m0_rvalid, res_rd}), 32'b11);
    m0_req = 1'b1;
    reset = 1'b0;
    #1;
    chk("t6_gnt", 32'({m0_gnt, m1_gnt}), 32'(0));
    chk("t6_rd_wr", 32'({res_rd, res_wr}), 32'(0));
    chk("t6_addr_do", 32'({res_addr, res_do}), 32'(0));
    chk("t6_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'(0));
    @(negedge clk);
    @(negedge clk);
    set_m0(1'b0, 1'b0, 1'b0, 14'h0, 8'h0);
    set_m1(1'b0, 1'b0, 1'b0, 14'h0, 8'h0);
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_no_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'(0));
    end

    // Random traffic with request hold-until-grant
    held0 = 1'b0; held1 = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!held0) gen(0);
      if (!held1) gen(1);
      tick();
      held0 = m0_req && last_g != 0;
      held1 = m1_req && last_g != 1;
    end
    m0_lock = 1'b0;
    m1_lock = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
